// File: rtl/bcd_stopwatch_cnt.sv
// BCD stopwatch: prescaled tick drives a ripple chain of BCD digit incrementers,
// with a ZERO/RUN/PAUSE control FSM, a lap snapshot register and a sticky overflow flag.
module bcd_stopwatch_cnt #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_stop,
  input  logic                    clr,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [4*NUM_DIGITS-1:0] lap_digits,
  output logic                    running,
  output logic                    ovf
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [PW-1:0]           presc;
  logic                    tick;
  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] digits_inc;

  assign carry[0] = 1'b1;

  // Ripple chain: a digit wraps to 0 and carries out only when it is 9 and carried into.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [3:0] d;
    assign d              = digits[4*i +: 4];
    assign carry[i+1]     = (d == 4'd9) && carry[i];
    assign digits_inc[4*i +: 4] = carry[i+1] ? 4'd0 : (d + {3'b000, carry[i]});
  end

  always_comb begin
    tick       = (state == RUN) && (presc == PRESC_LAST);
    next_state = state;
    if (start_stop) begin
      case (state)
        ZERO:    next_state = RUN;
        RUN:     next_state = PAUSE;
        PAUSE:   next_state = RUN;
        default: next_state = ZERO;
      endcase
    end else begin
      next_state = state;
    end
  end

  // clr outranks every other control; lap samples the count as it stood before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ZERO;
      presc      <= '0;
      digits     <= '0;
      lap_digits <= '0;
      running    <= 1'b0;
      ovf        <= 1'b0;
    end else if (clr) begin
      state      <= ZERO;
      presc      <= '0;
      digits     <= '0;
      lap_digits <= '0;
      running    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
      if (lap) begin
        lap_digits <= digits;
      end
      if (state == RUN) begin
        presc <= tick ? '0 : presc + 1'b1;
      end else if (state == ZERO) begin
        presc <= '0;
      end
      if (tick) begin
        digits <= digits_inc;
        if (carry[NUM_DIGITS]) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_cnt.sv
// Scoreboard bench for bcd_stopwatch_cnt: an integer-arithmetic stopwatch model queues the
// expected outputs after each edge; a negedge monitor pops and compares against the DUT.
module tb_bcd_stopwatch_cnt;
  localparam int ND  = 4;
  localparam int PS  = 4;
  localparam int MOD = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_stop = 1'b0;
  logic          clr = 1'b0;
  logic          lap = 1'b0;
  logic [4*ND-1:0] digits;
  logic [4*ND-1:0] lap_digits;
  logic          running;
  logic          ovf;

  bcd_stopwatch_cnt #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clr(clr), .lap(lap),
    .digits(digits), .lap_digits(lap_digits), .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*ND-1:0] d;
    logic [4*ND-1:0] l;
    logic            r;
    logic            o;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model: count and lap held as plain integers, the timebase as a cycle counter.
  bit m_run;
  bit m_ovf;
  int m_count;
  int m_lap;
  int m_pre;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic cycle(input bit ss, input bit cl, input bit lp, input bit rn);
    bit   tk;
    exp_t e;
    start_stop = ss;
    clr        = cl;
    lap        = lp;
    rst_n      = rn;
    if (!rn || cl) begin
      m_run = 1'b0; m_ovf = 1'b0; m_count = 0; m_lap = 0; m_pre = 0;
    end else begin
      tk = m_run && (m_pre == PS - 1);
      if (lp) m_lap = m_count;
      if (m_run) m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
        if (m_count == MOD - 1) m_ovf = 1'b1;
        m_count = (m_count + 1) % MOD;
      end
      if (ss) m_run = !m_run;
    end
    @(posedge clk);
    e.d = to_bcd(m_count);
    e.l = to_bcd(m_lap);
    e.r = m_run;
    e.o = m_ovf;
    exp_q.push_back(e);
    cyc++;
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: one comparison per clock, decoupled from the stimulus process.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (digits !== e.d || lap_digits !== e.l || running !== e.r || ovf !== e.o) begin
        bad++;
        $display("FAIL outputs cyc=%0d got d=%h l=%h run=%b ovf=%b exp d=%h l=%h run=%b ovf=%b",
                 cyc, digits, lap_digits, running, ovf, e.d, e.l, e.r, e.o);
      end
    end
  end

  initial begin
    // reset and basic counting: 10 ticks in 40 cycles
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(40);

    // lap coincident with the tick that takes 0009 to 0010
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(39);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);

    // pause mid-period, hold 20 cycles, resume
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(20);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(8);

    // clr + start_stop + lap together while running at 0123
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(123 * PS);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    idle(6);

    // reset pulse mid-run at 0456; needs start_stop to resume
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(456 * PS);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);

    // wrap 9999 -> 0000 sets ovf, which then sticks while counting continues
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(MOD * PS + 2 * PS);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);

    // randomized control traffic
    for (int k = 0; k < 4000; k++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 499) != 0));
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
